// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, loop-bound defaults and stride/width helpers
// for the convolution filter address generator.
package conv_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int DEF_IN_CH     = 32;
    localparam int DEF_ROW_ITERS = 6;
    localparam int DEF_OUT_F     = 64;
    localparam int DEF_KSIZE     = 3;

    function automatic int filter_stride(input int in_ch, input int ksize);
        return in_ch * ksize;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// conv_loop_counter: modulo-N loop counter; wrap flags the increment that rolls it back to 0.
module conv_loop_counter
    import conv_pkg::*;
#(
    parameter int N = 2,
    parameter int W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = inc && cnt == W'(N - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (inc) cnt <= wrap ? '0 : cnt + W'(1);

endmodule

// File: rtl/conv_filter_addr_gen.sv
// conv_filter_addr_gen: streams filter-weight addresses (channel > row group > filter > tap)
// over valid/ready. Define CONV_FILTER_LAST_EN to add last_out and row_last_out.
module conv_filter_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int IN_CH      = DEF_IN_CH,
    parameter int ROW_ITERS  = DEF_ROW_ITERS,
    parameter int OUT_F      = DEF_OUT_F,
    parameter int KSIZE      = DEF_KSIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_filter_addr,
    input  logic                  ready_in,
    output logic [ADDR_WIDTH-1:0] filter_address,
    output logic                  valid_out,
    output logic                  filter_start_out,
    output logic                  busy,
    output logic                  done
`ifdef CONV_FILTER_LAST_EN
    ,
    output logic                  last_out,
    output logic                  row_last_out
`endif
);

    localparam int KW = cnt_width(KSIZE);
    localparam int FW = cnt_width(OUT_F);
    localparam int RW = cnt_width(ROW_ITERS);
    localparam int CW = cnt_width(IN_CH);
    localparam logic [ADDR_WIDTH-1:0] STEP_CH = ADDR_WIDTH'(KSIZE);
    // From the last tap of one filter to tap 0 of the next filter.
    localparam logic [ADDR_WIDTH-1:0] STEP_F = ADDR_WIDTH'(filter_stride(IN_CH, KSIZE) - KSIZE + 1);

    state_t state, state_n;
    logic [KW-1:0] k;
    logic [FW-1:0] f;
    logic [RW-1:0] row;
    logic [CW-1:0] ch;
    logic k_wrap, f_wrap, row_wrap, ch_wrap;
    logic accept, fire;
    logic [ADDR_WIDTH-1:0] ch_base;

    assign accept = state == S_IDLE && start && !abort;
    assign fire   = state == S_RUN && ready_in && !abort;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= state_n;

    always_comb begin
        state_n = abort ? S_IDLE :
                  accept ? S_RUN :
                  (fire && ch_wrap) ? S_DONE :
                  (state == S_DONE) ? S_IDLE : state;
    end

    conv_loop_counter #(.N(KSIZE))     u_k   (.clk(clk), .rst(rst), .clear(accept), .inc(fire),     .cnt(k),   .wrap(k_wrap));
    conv_loop_counter #(.N(OUT_F))     u_f   (.clk(clk), .rst(rst), .clear(accept), .inc(k_wrap),   .cnt(f),   .wrap(f_wrap));
    conv_loop_counter #(.N(ROW_ITERS)) u_row (.clk(clk), .rst(rst), .clear(accept), .inc(f_wrap),   .cnt(row), .wrap(row_wrap));
    conv_loop_counter #(.N(IN_CH))     u_ch  (.clk(clk), .rst(rst), .clear(accept), .inc(row_wrap), .cnt(ch),  .wrap(ch_wrap));

    // ch_base tracks base + ch*KSIZE so each row pass can rewind to filter 0 without a multiply.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            filter_address <= '0;
            ch_base        <= '0;
        end else if (accept) begin
            filter_address <= base_filter_addr;
            ch_base        <= base_filter_addr;
        end else if (fire) begin
            if (row_wrap) begin
                filter_address <= ch_base + STEP_CH;
                ch_base        <= ch_base + STEP_CH;
            end else if (f_wrap) filter_address <= ch_base;
            else if (k_wrap) filter_address <= filter_address + STEP_F;
            else filter_address <= filter_address + ADDR_WIDTH'(1);
        end

    assign valid_out        = state == S_RUN;
    assign busy             = state == S_RUN;
    assign done             = state == S_DONE;
    assign filter_start_out = valid_out && k == '0;

`ifdef CONV_FILTER_LAST_EN
    assign row_last_out = valid_out && f == FW'(OUT_F - 1) && k == KW'(KSIZE - 1);
    assign last_out     = row_last_out && row == RW'(ROW_ITERS - 1) && ch == CW'(IN_CH - 1);
`else
    logic unused_cnt;
    assign unused_cnt = ^{f, row, ch};
`endif

endmodule

// File: doc/conv_filter_addr_gen.md
Name: conv_filter_addr_gen

Overview:
Parametrised filter-weight address generator for the convolution layer. One address per beat is streamed to the weight memory over a valid/ready handshake, in loop order input channel → row group → output filter → kernel tap. Adds back-pressure, full throughput, abort, busy/done status and generic loop bounds. Sits between the layer controller (start/base) and the filter BRAM read port / weight buffer.

Parameters:
ADDR_WIDTH, 32, width of base and output address
IN_CH, 32, input channels (outermost loop)
ROW_ITERS, 6, row-group passes per input channel (filters re-read per pass)
OUT_F, 64, output filters
KSIZE, 3, kernel taps per filter row (innermost loop)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin sequence; sampled only in IDLE
abort  in  1  synchronous cancel; effective in any state
base_filter_addr  in  ADDR_WIDTH  filter base; latched on accepted start
ready_in  in  1  downstream accepts current address
filter_address  out  ADDR_WIDTH  current address
valid_out  out  1  filter_address valid
filter_start_out  out  1  qualifies beat with tap index 0 (first tap of a filter row)
busy  out  1  high in RUN
done  out  1  one-cycle pulse after final handshake

Behaviour:
- Reset: state=IDLE; filter_address=0, valid_out=0, filter_start_out=0, busy=0, done=0; all counters 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 (abort=0) → latch base, clear counters, go RUN. Next cycle valid_out=1, filter_address=base, filter_start_out=1. Start-to-first-valid latency: 1 cycle.
- RUN: busy=1, valid_out=1. Address = base + f*(IN_CH*KSIZE) + ch*KSIZE + k, mod 2^ADDR_WIDTH. Computed with incremental adders, no multipliers.
- Handshake: beat retires on valid_out && ready_in. While ready_in=0, filter_address and filter_start_out are held stable. Next address appears the cycle after a handshake. Continuous ready_in gives 1 address/cycle.
- Counter advance per handshake: k++; wrap at KSIZE → f++; wrap at OUT_F → row++; wrap at ROW_ITERS → ch++; wrap at IN_CH → final.
- Total beats: IN_CH*ROW_ITERS*OUT_F*KSIZE. Default is 36864.
- Final handshake: valid_out=0 next cycle, state=DONE, done=1 for exactly one cycle, then IDLE.
- start while RUN/DONE is ignored; no restart, no queueing.
- abort=1 in RUN: next cycle valid_out=0, busy=0, state=IDLE, no done pulse. abort has priority over a same-cycle handshake and over start.
- abort in IDLE or DONE: no effect beyond forcing IDLE. The DONE pulse still completes.
- Async rst mid-sequence: immediate return to reset values.
- Counter widths: $clog2 of each bound, minimum 1 bit. Parameters of 1 are legal (loop degenerates).

Optional Feature:
Macro CONV_FILTER_LAST_EN.
- Defined: extra output last_out (1 bit), asserted with valid_out on the final beat of the whole sequence only, held under back-pressure.
- Also adds output row_last_out, asserted on the last beat of each row-group pass (f=OUT_F-1, k=KSIZE-1).
- Not defined: neither port exists. Core behaviour is identical.

Decomposition:
- Shared package conv_pkg: state encoding localparams (S_IDLE/S_RUN/S_DONE), loop-bound defaults, and a function for derived strides (IN_CH*KSIZE).
- One sub-module, conv_loop_counter: parametrised wrapping counter with inc, clear and wrap outputs. It is instantiated four times and chained by wrap.

Test Plan:
- Small config: IN_CH=2, ROW_ITERS=2, OUT_F=2, KSIZE=3, base=0x100, ready_in=1 → 24 beats: 0x100,101,102,106,107,108 twice, then 0x103,104,105,109,10A,10B twice. filter_start_out on each 0x100/0x106/0x103/0x109 beat; done 1 cycle after beat 24.
- Same config with ready_in toggling 1,0,0,1… → address and filter_start_out held stable while ready_in=0; identical 24-address sequence; no duplicates, no skips.
- abort asserted after 5th handshake → valid_out=0 next cycle, busy=0, no done. A new start then restarts at base.
- start pulsed during RUN → ignored; sequence length still 24.
- Default parameters, base=0xFFFF_FFF0 → address wraps modulo 2^32; count 36864 beats then done. With CONV_FILTER_LAST_EN, last_out only on beat 36864.
- rst asserted mid-stream → all outputs 0 immediately; post-reset start → first address = new base.
